// File: rtl/usb_tx_pkg.sv
// Shared types for the USB transmit scheduler: packet codes, FSM states, line states.
package usb_tx_pkg;

  typedef enum logic [1:0] {
    NONE = 2'b00,
    DATA = 2'b01,
    ACK  = 2'b10,
    NAK  = 2'b11
  } tx_packet_t;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT_SOP,
    ACTIVE,
    EOP,
    GAP
  } sched_state_t;

  // Line state encoded as {dplus, dminus}
  localparam logic [1:0] LINE_J   = 2'b10;
  localparam logic [1:0] LINE_K   = 2'b01;
  localparam logic [1:0] LINE_SE0 = 2'b00;

endpackage

// File: rtl/usb_tx_line_mon.sv
// Decodes the transmitter's line outputs and flags start-of-packet and EOP completion.
// Both flags are single-cycle, combinational against the previous-cycle line state.
module usb_tx_line_mon
  import usb_tx_pkg::*;
(
  input  logic       clk,
  input  logic       n_rst,
  input  logic       dplus_out,
  input  logic       dminus_out,
  output logic [1:0] line,
  output logic       sop,
  output logic       eop_done
);

  logic [1:0] prev;

  assign line     = {dplus_out, dminus_out};
  assign sop      = (prev == LINE_J)   && (line != LINE_J);
  assign eop_done = (prev == LINE_SE0) && (line == LINE_J);

  // Remember last cycle's line state; the bus idles in J.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) prev <= LINE_J;
    else        prev <= line;
  end

endmodule

// File: rtl/usb_tx_sched.sv
// Transmit scheduler: arbitrates handshake vs. data requests, launches packets into
// usb_tx, follows the packet on the line, enforces the inter-packet gap and a timeout.
module usb_tx_sched
  import usb_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT   = 4,
  parameter int GAP_BITS       = 2,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int MAX_DATA       = 64
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       hs_req,
  input  logic       hs_type,
  input  logic       data_req,
  input  logic [6:0] data_size,
  output logic       hs_gnt,
  output logic       data_gnt,
  output logic [1:0] tx_packet,
  output logic [6:0] tx_packet_size,
  input  logic       get_tx_packet_data,
  output logic       buffer_pop,
  input  logic       dplus_out,
  input  logic       dminus_out,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_err
);

  localparam int GAP_CYC = GAP_BITS * CLKS_PER_BIT;
  localparam int GW      = $clog2(GAP_CYC + 1);
  localparam int TW      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYC - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [6:0]    MAX_SZ   = 7'(MAX_DATA);

  sched_state_t state, state_n;
  tx_packet_t   type_q, type_n, pkt_q, pkt_n;
  logic [6:0]   size_q, size_n, pop_cnt;
  logic [GW-1:0] gap_cnt;
  logic [TW-1:0] to_cnt;
  logic hs_gnt_n, data_gnt_n, done_n, err_n, busy_n;
  logic timeout;
  logic [1:0] line;
  logic sop, eop_done;

  usb_tx_line_mon u_line_mon (
    .clk        (clk),
    .n_rst      (n_rst),
    .dplus_out  (dplus_out),
    .dminus_out (dminus_out),
    .line       (line),
    .sop        (sop),
    .eop_done   (eop_done)
  );

  assign tx_packet      = pkt_q;
  assign tx_packet_size = size_q;
  assign timeout        = (to_cnt == TO_LAST);

  // Byte fetches pass straight through, but only while our own DATA packet is on the wire.
  assign buffer_pop = get_tx_packet_data && (type_q == DATA) &&
                      ((state == WAIT_SOP) || (state == ACTIVE));

  // Next-state and next-output decode. The grant that ends IDLE is still visible
  // in the following IDLE cycle after an oversize reject, so arbitration is held
  // off while data_gnt is high to avoid granting the same request twice.
  always_comb begin
    state_n    = state;
    type_n     = type_q;
    pkt_n      = pkt_q;
    size_n     = size_q;
    hs_gnt_n   = 1'b0;
    data_gnt_n = 1'b0;
    done_n     = 1'b0;
    err_n      = 1'b0;
    busy_n     = tx_busy;
    case (state)
      IDLE: begin
        if (!data_gnt) begin
          if (hs_req) begin
            state_n  = LAUNCH;
            hs_gnt_n = 1'b1;
            type_n   = hs_type ? NAK : ACK;
            pkt_n    = hs_type ? NAK : ACK;
            size_n   = 7'd0;
            busy_n   = 1'b1;
          end else if (data_req) begin
            data_gnt_n = 1'b1;
            if (data_size > MAX_SZ) begin
              err_n = 1'b1;
            end else begin
              state_n = LAUNCH;
              type_n  = DATA;
              pkt_n   = DATA;
              size_n  = data_size;
              busy_n  = 1'b1;
            end
          end
        end
      end
      LAUNCH: state_n = WAIT_SOP;
      WAIT_SOP: begin
        if (timeout) begin
          state_n = GAP;
          pkt_n   = NONE;
          err_n   = 1'b1;
        end else if (sop) begin
          state_n = ACTIVE;
          pkt_n   = NONE;
        end
      end
      ACTIVE: begin
        if (timeout) begin
          state_n = GAP;
          pkt_n   = NONE;
          err_n   = 1'b1;
        end else if (line == LINE_SE0) begin
          state_n = EOP;
        end
      end
      EOP: begin
        if (timeout) begin
          state_n = GAP;
          pkt_n   = NONE;
          err_n   = 1'b1;
        end else if (eop_done) begin
          state_n = GAP;
          if ((type_q == DATA) && (pop_cnt != size_q)) err_n  = 1'b1;
          else                                         done_n = 1'b1;
        end
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) begin
          state_n = IDLE;
          busy_n  = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state    <= IDLE;
      type_q   <= NONE;
      pkt_q    <= NONE;
      size_q   <= 7'd0;
      hs_gnt   <= 1'b0;
      data_gnt <= 1'b0;
      tx_done  <= 1'b0;
      tx_err   <= 1'b0;
      tx_busy  <= 1'b0;
    end else begin
      state    <= state_n;
      type_q   <= type_n;
      pkt_q    <= pkt_n;
      size_q   <= size_n;
      hs_gnt   <= hs_gnt_n;
      data_gnt <= data_gnt_n;
      tx_done  <= done_n;
      tx_err   <= err_n;
      tx_busy  <= busy_n;
    end
  end

  // Pop, timeout and gap counters; each restarts when its phase is entered.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      pop_cnt <= 7'd0;
      to_cnt  <= '0;
      gap_cnt <= '0;
    end else begin
      if (state == LAUNCH)                        pop_cnt <= 7'd0;
      else if (buffer_pop && (pop_cnt != 7'd127)) pop_cnt <= pop_cnt + 7'd1;

      if ((state == WAIT_SOP) || (state == ACTIVE) || (state == EOP)) to_cnt <= to_cnt + 1'b1;
      else                                                           to_cnt <= '0;

      if (state == GAP) gap_cnt <= gap_cnt + 1'b1;
      else              gap_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_usb_tx_sched.sv
// Directed bench for usb_tx_sched: a table of complete transactions plus hand-written
// sequences for arbitration priority, oversize reject, timeout and mid-packet reset.
module tb_usb_tx_sched;

  localparam logic [1:0] LJ   = 2'b10;
  localparam logic [1:0] LK   = 2'b01;
  localparam logic [1:0] LSE0 = 2'b00;

  logic       clk, n_rst;
  logic       hs_req, hs_type, data_req;
  logic [6:0] data_size;
  logic       hs_gnt, data_gnt;
  logic [1:0] tx_packet;
  logic [6:0] tx_packet_size;
  logic       get_tx_packet_data, buffer_pop;
  logic       dplus_out, dminus_out;
  logic       tx_busy, tx_done, tx_err;

  int tests = 0;
  int fails = 0;
  string ctx = "init";

  usb_tx_sched dut (
    .clk                (clk),
    .n_rst              (n_rst),
    .hs_req             (hs_req),
    .hs_type            (hs_type),
    .data_req           (data_req),
    .data_size          (data_size),
    .hs_gnt             (hs_gnt),
    .data_gnt           (data_gnt),
    .tx_packet          (tx_packet),
    .tx_packet_size     (tx_packet_size),
    .get_tx_packet_data (get_tx_packet_data),
    .buffer_pop         (buffer_pop),
    .dplus_out          (dplus_out),
    .dminus_out         (dminus_out),
    .tx_busy            (tx_busy),
    .tx_done            (tx_done),
    .tx_err             (tx_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // One table entry = one complete transaction and its expected results.
  typedef struct {
    logic       hr, ht, dr;
    logic [6:0] ds;
    int         ngets;
    logic [1:0] epkt;
    logic [6:0] esz;
    logic       ehg, edg, pop_en, edone, eerr;
  } row_t;

  row_t tbl [7];

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_line(input logic [1:0] l);
    {dplus_out, dminus_out} = l;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s/%s: got %0h expected %0h", ctx, name, got, exp);
    end
  endtask

  function automatic logic [14:0] outs();
    return {hs_gnt, data_gnt, tx_packet, tx_packet_size, buffer_pop, tx_busy, tx_done, tx_err};
  endfunction

  // Drives the line from the cycle after LAUNCH through the end of the gap.
  task automatic line_body(input int ngets, input logic pop_en, input logic [1:0] epkt,
                           input logic edone, input logic eerr);
    int   pops;
    logic stray;
    pops  = 0;
    stray = 1'b0;
    tick(); set_line(LJ); #1;
    chk("pkt_hold", tx_packet, epkt);
    stray |= hs_gnt | data_gnt;
    tick(); set_line(LK); #1;
    stray |= hs_gnt | data_gnt;
    tick(); set_line(LJ); #1;
    chk("pkt_clear", tx_packet, 2'b00);
    for (int i = 0; i < ngets; i++) begin
      tick(); set_line((i % 2 == 0) ? LK : LJ); get_tx_packet_data = 1'b1; #1;
      pops += int'(buffer_pop);
      stray |= hs_gnt | data_gnt;
    end
    tick(); get_tx_packet_data = 1'b0; set_line(LSE0); #1;
    tick(); set_line(LSE0); #1;
    tick(); set_line(LJ); #1;
    chk("done_early", tx_done, 1'b0);
    tick(); #1;
    chk("done", tx_done, edone);
    chk("err", tx_err, eerr);
    for (int i = 0; i < 7; i++) begin
      tick(); #1;
      if (i == 0) chk("done_pulse", tx_done, 1'b0);
      stray |= hs_gnt | data_gnt;
    end
    chk("busy_gap", tx_busy, 1'b1);
    tick(); #1;
    chk("busy_fall", tx_busy, 1'b0);
    chk("pops", pops, pop_en ? ngets : 0);
    chk("no_gnt_busy", stray, 1'b0);
  endtask

  task automatic run_txn(input row_t r);
    tick(); hs_req = r.hr; hs_type = r.ht; data_req = r.dr; data_size = r.ds; #1;
    chk("idle_busy", tx_busy, 1'b0);
    tick(); hs_req = 1'b0; data_req = 1'b0; #1;
    chk("hs_gnt", hs_gnt, r.ehg);
    chk("data_gnt", data_gnt, r.edg);
    chk("pkt", tx_packet, r.epkt);
    chk("size", tx_packet_size, r.esz);
    chk("busy", tx_busy, 1'b1);
    line_body(r.ngets, r.pop_en, r.epkt, r.edone, r.eerr);
  endtask

  initial begin
    int   k;
    logic seen, done_seen;

    // fields: hr ht dr ds ngets epkt esz ehg edg pop_en edone eerr
    tbl[0] = '{1'b1, 1'b0, 1'b0, 7'd0,  0,  2'b10, 7'd0,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0}; // ACK
    tbl[1] = '{1'b1, 1'b1, 1'b0, 7'd0,  2,  2'b11, 7'd0,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0}; // NAK, fetches gated
    tbl[2] = '{1'b0, 1'b0, 1'b1, 7'd8,  8,  2'b01, 7'd8,  1'b0, 1'b1, 1'b1, 1'b1, 1'b0}; // DATA 8 ok
    tbl[3] = '{1'b0, 1'b0, 1'b1, 7'd8,  7,  2'b01, 7'd8,  1'b0, 1'b1, 1'b1, 1'b0, 1'b1}; // short by one
    tbl[4] = '{1'b0, 1'b0, 1'b1, 7'd0,  0,  2'b01, 7'd0,  1'b0, 1'b1, 1'b1, 1'b1, 1'b0}; // zero-length
    tbl[5] = '{1'b0, 1'b0, 1'b1, 7'd64, 64, 2'b01, 7'd64, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0}; // max size
    tbl[6] = '{1'b0, 1'b0, 1'b1, 7'd3,  5,  2'b01, 7'd3,  1'b0, 1'b1, 1'b1, 1'b0, 1'b1}; // too many pops

    n_rst = 1'b0; hs_req = 1'b0; hs_type = 1'b0; data_req = 1'b0; data_size = 7'd0;
    get_tx_packet_data = 1'b0;
    set_line(LJ);

    ctx = "reset";
    tick(); tick(); #1;
    chk("outs_in_reset", outs(), 15'd0);
    tick(); n_rst = 1'b1; #1;
    chk("outs_after_release", outs(), 15'd0);

    for (int i = 0; i < 7; i++) begin
      ctx = $sformatf("row%0d", i);
      run_txn(tbl[i]);
    end

    // Simultaneous requests: handshake first, data waits out the gap.
    ctx = "priority";
    tick(); hs_req = 1'b1; hs_type = 1'b1; data_req = 1'b1; data_size = 7'd8; #1;
    tick(); hs_req = 1'b0; #1;
    chk("hs_first", hs_gnt, 1'b1);
    chk("data_held", data_gnt, 1'b0);
    chk("pkt_nak", tx_packet, 2'b11);
    line_body(0, 1'b0, 2'b11, 1'b1, 1'b0);
    tick(); data_req = 1'b0; #1;
    chk("data_gnt_late", data_gnt, 1'b1);
    chk("pkt_data", tx_packet, 2'b01);
    chk("size_data", tx_packet_size, 7'd8);
    line_body(8, 1'b1, 2'b01, 1'b1, 1'b0);

    // Oversize request: rejected in place, request held through the grant cycle.
    ctx = "oversize";
    tick(); data_req = 1'b1; data_size = 7'd65; #1;
    tick(); #1;
    chk("gnt", data_gnt, 1'b1);
    chk("err", tx_err, 1'b1);
    chk("pkt", tx_packet, 2'b00);
    chk("busy", tx_busy, 1'b0);
    tick(); data_req = 1'b0; #1;
    chk("no_regrant", data_gnt, 1'b0);
    chk("err_pulse", tx_err, 1'b0);
    chk("busy_after", tx_busy, 1'b0);

    // Line never leaves J: timeout after TIMEOUT_CYCLES of waiting.
    ctx = "timeout";
    tick(); hs_req = 1'b1; hs_type = 1'b0; #1;
    tick(); hs_req = 1'b0; #1;
    chk("gnt", hs_gnt, 1'b1);
    k = 0; seen = 1'b0; done_seen = 1'b0;
    while (k < 4200 && !seen) begin
      tick(); #1;
      k++;
      done_seen |= tx_done;
      if (tx_err) seen = 1'b1;
      else if (k == 4096) chk("pkt_hold", tx_packet, 2'b10);
    end
    chk("err_cycle", k, 4097);
    chk("pkt_forced", tx_packet, 2'b00);
    chk("no_done", done_seen, 1'b0);
    repeat (7) tick();
    #1;
    chk("busy_gap", tx_busy, 1'b1);
    tick(); #1;
    chk("busy_fall", tx_busy, 1'b0);

    // Reset during ACTIVE with a fetch strobe high, then a normal handshake.
    ctx = "mid_reset";
    tick(); data_req = 1'b1; data_size = 7'd4; #1;
    tick(); data_req = 1'b0; #1;
    chk("gnt", data_gnt, 1'b1);
    tick(); set_line(LJ); #1;
    tick(); set_line(LK); #1;
    tick(); set_line(LJ); get_tx_packet_data = 1'b1; #1;
    chk("pop_before", buffer_pop, 1'b1);
    tick(); n_rst = 1'b0; #1;
    chk("outs_reset", outs(), 15'd0);
    tick(); n_rst = 1'b1; get_tx_packet_data = 1'b0; #1;
    chk("outs_release", outs(), 15'd0);
    ctx = "post_reset";
    run_txn(tbl[0]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
